common_if_rr_arbiter: RTL and testbench

- N-channel successor to the single-master common interface.
- Accepts NCH independent master-side command/write/read channels and arbitrates them round-robin onto one slave-side common-interface port, e.g. a shared I2C master core.
- A grant is locked from command acceptance until the slave signals finish, so bursts never interleave.
- Adds a per-transaction watchdog that aborts a hung transfer.

---
 rtl/common_if_pkg.sv | 18 +
 rtl/common_if_rr_arbiter_if.sv | 39 +++
 rtl/rr_select.sv | 32 +++
 rtl/common_if_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_common_if_rr_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/common_if_pkg.sv
// Shared types and constants for the round-robin common-interface arbiter.
package common_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  localparam int STATUS_W = 5;
  localparam logic [STATUS_W-1:0] STATUS_TMO = 5'h1F;

  // Width of an index into n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/common_if_rr_arbiter_if.sv
// Common-interface bundle: command, write and read channels for N lanes.
// A master issues commands and write data; a slave accepts them and
// returns read data, status and finish.
interface common_if_rr_arbiter_if #(
  parameter int N     = 4,
  parameter int CSIZE = 4,
  parameter int LSIZE = 24,
  parameter int DSIZE = 32,
  parameter int ASIZE = 10
);
  import common_if_pkg::*;

  logic [N-1:0]          cmd_vld;
  logic [N*CSIZE-1:0]    cmd;
  logic [N*ASIZE-1:0]    addr;
  logic [N*LSIZE-1:0]    burst_len;
  logic [N-1:0]          cmd_ready;
  logic [N-1:0]          finish;
  logic [N*STATUS_W-1:0] status;
  logic [N-1:0]          wr_vld;
  logic [N-1:0]          wr_last;
  logic [N*DSIZE-1:0]    wr_data;
  logic [N-1:0]          wr_ready;
  logic [N-1:0]          rd_ready;
  logic [N-1:0]          rd_vld;
  logic [N-1:0]          rd_last;
  logic [N*DSIZE-1:0]    rd_data;

  modport master (
    output cmd_vld, cmd, addr, burst_len, wr_vld, wr_last, wr_data, rd_ready,
    input  cmd_ready, finish, status, wr_ready, rd_vld, rd_last, rd_data
  );

  modport slave (
    input  cmd_vld, cmd, addr, burst_len, wr_vld, wr_last, wr_data, rd_ready,
    output cmd_ready, finish, status, wr_ready, rd_vld, rd_last, rd_data
  );

endinterface

// File: rtl/rr_select.sv
// Round-robin pick: first set request at or after ptr_i, wrapping modulo N.
module rr_select
  import common_if_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          vld_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Walk candidates from the highest rotated position down so the lowest
  // rotated offset (closest to the pointer) wins.
  always_comb begin
    sum   = '0;
    cand  = '0;
    idx_o = '0;
    vld_o = |req_i;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_i} + (IW + 1)'(i);
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      cand = sum[IW-1:0];
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/common_if_rr_arbiter.sv
// N-channel round-robin arbiter onto one common-interface slave port.
// A grant is held from command acceptance to finish; a watchdog aborts
// transfers the slave never finishes.
module common_if_rr_arbiter
  import common_if_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CSIZE = 4,
  parameter int LSIZE = 24,
  parameter int DSIZE = 32,
  parameter int ASIZE = 10,
  parameter int TMO   = 65535
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    clk_en,
  common_if_rr_arbiter_if.slave   s,
  common_if_rr_arbiter_if.master  m,
  output logic [$clog2(NCH)-1:0]  grant_id,
  output logic                    busy,
  output logic                    tmo_err
);

  localparam int IW = idx_w(NCH);
  localparam int WW = (TMO > 1) ? $clog2(TMO + 1) : 1;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, sel_idx, gnt_nxt;
  logic [WW-1:0] wdog_q, wdog_d, wdog_inc;
  logic          tmo_q, tmo_d;
  logic          sel_vld, in_cmd, in_xfer, cmd_hs, fin_pass, wdog_hit;

  logic [CSIZE-1:0] cmd_a  [NCH];
  logic [ASIZE-1:0] addr_a [NCH];
  logic [LSIZE-1:0] len_a  [NCH];
  logic [DSIZE-1:0] wdat_a [NCH];

  rr_select #(.N(NCH), .IW(IW)) u_sel (
    .req_i (s.cmd_vld),
    .ptr_i (ptr_q),
    .vld_o (sel_vld),
    .idx_o (sel_idx)
  );

  assign in_cmd   = (state_q == CMD);
  assign in_xfer  = (state_q == XFER);
  assign cmd_hs   = in_cmd & s.cmd_vld[gnt_q] & m.cmd_ready;
  // Finish is honoured in XFER, or when it coincides with the command handshake.
  assign fin_pass = in_xfer | cmd_hs;
  assign gnt_nxt  = (gnt_q == IW'(NCH - 1)) ? '0 : gnt_q + 1'b1;
  assign wdog_inc = (&wdog_q) ? wdog_q : wdog_q + 1'b1;
  assign wdog_hit = (TMO != 0) && (wdog_inc == WW'(TMO));

  // Next-state, grant, pointer and watchdog decisions.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    wdog_d  = wdog_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gnt_d   = sel_idx;
          state_d = CMD;
          wdog_d  = '0;
        end
      end
      CMD: begin
        wdog_d = wdog_inc;
        if (!s.cmd_vld[gnt_q]) begin
          state_d = IDLE;
        end else if (m.cmd_ready) begin
          if (m.finish) begin
            state_d = IDLE;
            ptr_d   = gnt_nxt;
          end else begin
            state_d = XFER;
          end
        end
      end
      XFER: begin
        wdog_d = wdog_inc;
        if (m.finish) begin
          state_d = IDLE;
          ptr_d   = gnt_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
    // Watchdog abort only applies to a transaction that would otherwise continue.
    if (state_q != IDLE && state_d != IDLE && wdog_hit) begin
      state_d = IDLE;
      ptr_d   = gnt_nxt;
      tmo_d   = 1'b1;
    end
  end

  // State registers, updated only on enabled cycles.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
    end
  end

  assign grant_id = gnt_q;
  assign busy     = (state_q != IDLE);
  assign tmo_err  = tmo_q;

  // Downstream side: granted channel's fields, valids gated by state.
  assign m.cmd_vld   = in_cmd & s.cmd_vld[gnt_q];
  assign m.cmd       = cmd_a[gnt_q];
  assign m.addr      = addr_a[gnt_q];
  assign m.burst_len = len_a[gnt_q];
  assign m.wr_vld    = in_xfer & s.wr_vld[gnt_q];
  assign m.wr_last   = in_xfer & s.wr_last[gnt_q];
  assign m.wr_data   = wdat_a[gnt_q];
  assign m.rd_ready  = in_xfer & s.rd_ready[gnt_q];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic own;
    assign own       = (gnt_q == IW'(i));
    assign cmd_a[i]  = s.cmd[i*CSIZE +: CSIZE];
    assign addr_a[i] = s.addr[i*ASIZE +: ASIZE];
    assign len_a[i]  = s.burst_len[i*LSIZE +: LSIZE];
    assign wdat_a[i] = s.wr_data[i*DSIZE +: DSIZE];

    assign s.cmd_ready[i] = own & in_cmd & m.cmd_ready;
    assign s.wr_ready[i]  = own & in_xfer & m.wr_ready;
    assign s.rd_vld[i]    = own & in_xfer & m.rd_vld;
    assign s.rd_last[i]   = own & in_xfer & m.rd_last;
    assign s.rd_data[i*DSIZE +: DSIZE] = (own & in_xfer) ? m.rd_data : '0;
    assign s.finish[i]    = own & ((fin_pass & m.finish) | tmo_q);
    assign s.status[i*STATUS_W +: STATUS_W] =
      !own     ? '0 :
      tmo_q    ? STATUS_TMO :
      fin_pass ? m.status : '0;
  end

endmodule

// File: tb/tb_common_if_rr_arbiter.sv
// Directed bench for common_if_rr_arbiter with a grant-order scoreboard.
module tb_common_if_rr_arbiter;
  localparam int NCH   = 4;
  localparam int CSIZE = 4;
  localparam int LSIZE = 24;
  localparam int DSIZE = 32;
  localparam int ASIZE = 10;
  localparam int TMO   = 16;

  logic       clock;
  logic       rst_n;
  logic       clk_en;
  logic [1:0] grant_id;
  logic       busy;
  logic       tmo_err;

  int n_vec = 0;
  int n_err = 0;
  logic       mon_en = 1'b0;
  logic       have_last = 1'b0;
  logic [1:0] last_g = '0;
  int         sb_q[$];

  common_if_rr_arbiter_if #(.N(NCH), .CSIZE(CSIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .ASIZE(ASIZE)) up ();
  common_if_rr_arbiter_if #(.N(1),   .CSIZE(CSIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .ASIZE(ASIZE)) dn ();

  common_if_rr_arbiter #(
    .NCH(NCH), .CSIZE(CSIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .ASIZE(ASIZE), .TMO(TMO)
  ) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .s        (up),
    .m        (dn),
    .grant_id (grant_id),
    .busy     (busy),
    .tmo_err  (tmo_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each accepted downstream command pops the expected owner.
  always @(negedge clock) begin
    if (mon_en && rst_n && clk_en && dn.cmd_vld[0] && dn.cmd_ready[0]) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        chk("t2_grant_order", 128'(grant_id), 128'(sb_q.pop_front()));
        if (have_last) chk("t2_no_repeat", 128'(grant_id == last_g), 0);
        last_g    = grant_id;
        have_last = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running, expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    up.cmd_vld = '0; up.cmd = '0; up.addr = '0; up.burst_len = '0;
    up.wr_vld = '0; up.wr_last = '0; up.wr_data = '0; up.rd_ready = '0;
    dn.cmd_ready = '0; dn.finish = '0; dn.status = '0; dn.wr_ready = '0;
    dn.rd_vld = '0; dn.rd_last = '0; dn.rd_data = '0;
    rst_n = 1'b0; clk_en = 1'b1;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_grant", 128'(grant_id), 0);
    chk("rst_tmo", 128'(tmo_err), 0);
    chk("rst_m_valids", 128'({dn.cmd_vld, dn.wr_vld, dn.rd_ready}), 0);
    chk("rst_s_outs", 128'({up.cmd_ready, up.finish, up.wr_ready, up.rd_vld}), 0);
    rst_n = 1'b1;

    // Test 1: single requester ch2, 4 write beats, finish
    up.cmd_vld = 4'b0100; up.cmd[8 +: 4] = 4'h3; up.addr[20 +: 10] = 10'h055;
    up.burst_len[48 +: 24] = 24'd4;
    @(negedge clock);
    chk("t1_grant", 128'(grant_id), 2);
    chk("t1_busy", 128'(busy), 1);
    chk("t1_m_cmd_vld", 128'(dn.cmd_vld), 1);
    chk("t1_m_fields", 128'({dn.cmd, dn.addr, dn.burst_len}), 128'({4'h3, 10'h055, 24'd4}));
    chk("t1_ready_wait", 128'(up.cmd_ready), 0);
    dn.cmd_ready = 1'b1; #1;
    chk("t1_ready_pass", 128'(up.cmd_ready), 128'(4'b0100));
    @(negedge clock);
    up.cmd_vld = '0; dn.cmd_ready = '0;
    for (int b = 0; b < 4; b++) begin
      up.wr_vld[2] = 1'b1; up.wr_last[2] = (b == 3);
      up.wr_data[64 +: 32] = 32'hA000_0000 + 32'(b); dn.wr_ready = 1'b1; #1;
      chk("t1_wr_beat", 128'({dn.wr_vld, dn.wr_last, dn.wr_data}),
          128'({1'b1, (b == 3), 32'hA000_0000 + 32'(b)}));
      chk("t1_wr_ready", 128'(up.wr_ready), 128'(4'b0100));
      @(negedge clock);
    end
    up.wr_vld = '0; up.wr_last = '0; dn.wr_ready = '0;
    dn.finish = 1'b1; dn.status = 5'h02; #1;
    chk("t1_finish", 128'(up.finish), 128'(4'b0100));
    chk("t1_status", 128'(up.status), 128'(20'h2 << 10));
    @(negedge clock);
    dn.finish = '0; dn.status = '0;
    chk("t1_idle_busy", 128'(busy), 0);
    // Pointer now 3: ch3 wins over ch0; finish coincides with command accept
    up.cmd_vld = 4'b1001; up.cmd[12 +: 4] = 4'h9;
    @(negedge clock);
    chk("t1_ptr_after", 128'(grant_id), 3);
    dn.cmd_ready = 1'b1; dn.finish = 1'b1; #1;
    chk("cmd_finish_pass", 128'(up.finish), 128'(4'b1000));
    @(negedge clock);
    up.cmd_vld = '0; dn.cmd_ready = '0; dn.finish = '0;
    chk("cmd_finish_idle", 128'(busy), 0);

    // Test 2: all channels request continuously, pointer starts at 0
    sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(2);
    sb_q.push_back(3); sb_q.push_back(0);
    mon_en = 1'b1; up.cmd_vld = 4'hF; dn.cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!(dn.cmd_vld[0] && dn.cmd_ready[0]) && n < 20) begin
        @(negedge clock);
        n++;
      end
      chk("t2_wait_bound", 128'(n >= 20), 0);
      @(negedge clock);
      if (k == 4) begin up.cmd_vld = '0; mon_en = 1'b0; end
      repeat (2) @(negedge clock);
      dn.finish = 1'b1;
      @(negedge clock);
      dn.finish = '0;
    end
    dn.cmd_ready = '0;
    chk("t2_sb_empty", 128'(sb_q.size()), 0);

    // Test 3: ch1 holds the grant while ch0 requests; pointer is 1
    up.cmd_vld = 4'b0010; up.cmd[4 +: 4] = 4'h5; dn.cmd_ready = 1'b1;
    @(negedge clock);
    chk("t3_grant1", 128'(grant_id), 1);
    @(negedge clock);
    up.cmd_vld = 4'b0001; up.cmd[0 +: 4] = 4'h7; up.wr_vld = 4'b0001;
    up.rd_ready = 4'b0011; dn.rd_vld = 1'b1; dn.rd_data = 32'hCAFE_0001; dn.wr_ready = 1'b1;
    #1;
    chk("t3_rd_vld", 128'(up.rd_vld), 128'(4'b0010));
    chk("t3_rd_data", 128'(up.rd_data), 128'(128'hCAFE_0001) << 32);
    chk("t3_m_rd_ready", 128'(dn.rd_ready), 1);
    for (int i = 0; i < 3; i++) begin
      chk("t3_ch0_blocked", 128'({up.cmd_ready, dn.cmd_vld, dn.wr_vld}), 0);
      chk("t3_grant_held", 128'(grant_id), 1);
      @(negedge clock); #1;
    end
    up.wr_vld = '0; up.rd_ready = '0; dn.rd_vld = '0; dn.rd_data = '0;
    dn.wr_ready = '0; dn.cmd_ready = '0; dn.finish = 1'b1;
    @(negedge clock);
    dn.finish = '0;
    @(negedge clock);
    chk("t3_grant0", 128'(grant_id), 0);
    chk("t3_ch0_cmd", 128'({dn.cmd_vld, dn.cmd}), 128'({1'b1, 4'h7}));
    dn.cmd_ready = 1'b1; dn.finish = 1'b1; #1;
    chk("t3_ch0_finish", 128'(up.finish), 128'(4'b0001));
    @(negedge clock);
    up.cmd_vld = '0; dn.cmd_ready = '0; dn.finish = '0;
    chk("t3_idle", 128'(busy), 0);

    // Test 4: watchdog, slave never finishes; pointer is 1
    up.cmd_vld = 4'b0100; dn.cmd_ready = 1'b1;
    @(negedge clock);
    chk("t4_grant2", 128'(grant_id), 2);
    @(negedge clock);
    up.cmd_vld = '0; dn.cmd_ready = '0;
    repeat (14) @(negedge clock);
    chk("t4_before_tmo", 128'({tmo_err, busy}), 128'(2'b01));
    @(negedge clock);
    chk("t4_tmo_pulse", 128'({tmo_err, busy}), 128'(2'b10));
    chk("t4_tmo_finish", 128'(up.finish), 128'(4'b0100));
    chk("t4_tmo_status", 128'(up.status), 128'(20'h1F << 10));
    @(negedge clock);
    chk("t4_after_tmo", 128'({tmo_err, busy, up.finish}), 0);

    // Test 5: clk_en one enabled edge in three, ch3 requesting; pointer is 3
    clk_en = 1'b0; up.cmd_vld = 4'b1000;
    repeat (2) @(negedge clock);
    chk("t5_no_grant_disabled", 128'(busy), 0);
    clk_en = 1'b1;
    @(negedge clock);
    chk("t5_grant_latency", 128'({busy, grant_id}), 128'({1'b1, 2'd3}));
    clk_en = 1'b0; dn.cmd_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("t5_cmd_held", 128'(up.cmd_ready), 128'(4'b1000));
    clk_en = 1'b1;
    @(negedge clock);
    clk_en = 1'b0; up.cmd_vld = '0; dn.cmd_ready = '0;
    for (int e = 0; e < 14; e++) begin
      repeat (2) @(negedge clock);
      clk_en = 1'b1;
      @(negedge clock);
      clk_en = 1'b0;
    end
    chk("t5_wdog_gated", 128'({tmo_err, busy}), 128'(2'b01));
    clk_en = 1'b1;
    @(negedge clock);
    chk("t5_tmo_pulse", 128'({tmo_err, busy}), 128'(2'b10));
    @(negedge clock);
    chk("t5_tmo_clear", 128'(tmo_err), 0);

    // Test 6: reset mid-transfer; pointer is 0
    up.cmd_vld = 4'b0010; dn.cmd_ready = 1'b1;
    @(negedge clock);
    chk("t6_grant1", 128'(grant_id), 1);
    @(negedge clock);
    up.cmd_vld = 4'hF; dn.cmd_ready = '0; up.wr_vld = 4'b0010; dn.wr_ready = 1'b1; #1;
    chk("t6_pre_reset_wr", 128'(dn.wr_vld), 1);
    #2 rst_n = 1'b0; #1;
    chk("t6_async_reset", 128'({busy, grant_id, tmo_err, dn.wr_vld, dn.cmd_vld}), 0);
    chk("t6_async_s_outs", 128'({up.wr_ready, up.finish, up.cmd_ready}), 0);
    @(negedge clock);
    rst_n = 1'b1; up.wr_vld = '0; dn.wr_ready = '0;
    @(negedge clock);
    chk("t6_first_grant", 128'({busy, grant_id, dn.cmd_vld}), 128'({1'b1, 2'd0, 1'b1}));
    up.cmd_vld = '0;
    @(negedge clock);
    chk("t6_drop_idle", 128'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
